debounce_filter: RTL and testbench
==================================

DEBOUNCE_FILTER -- requirements
Module: debounce_filter

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, number of independent filter channels (legal range 1..32).
REQ-002 The block SHALL have parameter DEPTH, default 3, number of consecutive equal samples required to change an output (legal range 2..16).
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops per channel (legal range 1..4).
REQ-004 The block SHALL have parameter DIV, default 1, number of clocks per sample tick (legal range 1..65535).
REQ-005 The block SHALL have port clock, input, 1 bit, clock; all state changes on the rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, reset, asynchronous, active-low.
REQ-007 The block SHALL have port enable, input, 1 bit; 1 = sampling active, 0 = prescaler and history frozen.
REQ-008 The block SHALL have port sig_in, input, CHANNELS bits, raw asynchronous channel inputs.
REQ-009 The block SHALL have port sig_out, output, CHANNELS bits, filtered levels (registered).
REQ-010 The block SHALL have port rise, output, CHANNELS bits, one-clock pulse when sig_out[i] goes 0->1.
REQ-011 The block SHALL have port fall, output, CHANNELS bits, one-clock pulse when sig_out[i] goes 1->0.
REQ-012 The block SHALL have port sample_tick, output, 1 bit, high during the clock in which a sample is taken.

Function
REQ-013 The synchronizer SHALL shift sig_in through SYNC_STAGES flops every clock, independent of enable and tick.
REQ-014 The prescaler SHALL count 0..DIV-1 while enable=1, wrap to 0 after DIV-1, and hold its value while enable=0.
REQ-015 sample_tick SHALL be 1 exactly when enable=1 and prescaler=DIV-1; for DIV=1 it SHALL equal enable.
REQ-016 On each clock edge where sample_tick=1, each channel's DEPTH-bit history SHALL shift in its synchronizer output, oldest bit discarded.
REQ-017 Output evaluation SHALL use the updated history on the same edge: all DEPTH bits 1 -> sig_out[i]=1; all 0 -> sig_out[i]=0; mixed -> hold.
REQ-018 With DIV=1 and enable=1, a clean level change on sig_in[i] SHALL appear on sig_out[i] exactly SYNC_STAGES+DEPTH clocks later.
REQ-019 Any input pulse shorter than DEPTH sample ticks SHALL leave sig_out unchanged.
REQ-020 rise[i]/fall[i] SHALL be registered, asserted in the same clock sig_out[i] changes, and held for exactly one clock.
REQ-021 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL produce simultaneous pulses.
REQ-022 When enable=0, history, sig_out and prescaler SHALL hold; rise and fall SHALL be 0.

Reset
REQ-023 Asserting reset SHALL immediately clear synchronizer, history, prescaler, sig_out, rise, fall and sample_tick to 0.
REQ-024 Reset asserted mid-window SHALL discard partial history; no rise or fall pulse SHALL result from reset.
REQ-025 After reset release, the first sample tick SHALL occur DIV clocks after the first edge with enable=1.

Configuration
REQ-026 When macro DEBOUNCE_FILTER_EDGE_EN is defined, rise and fall SHALL behave per REQ-010, REQ-011 and REQ-020.
REQ-027 When DEBOUNCE_FILTER_EDGE_EN is undefined, rise and fall SHALL remain present and tied to 0, with no edge-detect logic.

Verification
REQ-028 Defaults, enable=1, sig_in 0->4'b0001 held -> sig_out[0]=1 exactly 5 clocks later, rise[0]=1 for that one clock only.
REQ-029 Defaults, sig_in[1]=1 for 2 clocks then 0 -> sig_out stays 4'b0000, rise and fall stay 0.
REQ-030 DIV=4, enable=1 from reset release -> sample_tick high on clocks 4, 8, 12; step on sig_in[2] reaches sig_out within 2+3*4+4 clocks.
REQ-031 Defaults, sig_in[3] high, enable dropped after 2 ticks for 10 clocks then restored -> sig_out[3] rises on 1st tick after restore.
REQ-032 sig_out=4'hF, reset asserted asynchronously mid-cycle -> sig_out=4'h0 immediately, fall stays 0.
REQ-033 Build without DEBOUNCE_FILTER_EDGE_EN, repeat REQ-028 -> sig_out identical, rise and fall constant 0.

Source files
------------

// File: rtl/debounce_filter.sv
//------------------------------------------------------------------------------
// Module   : debounce_filter
// Brief    : Multi-channel synchronizer + N-sample debounce filter, edge pulses
//            present only when DEBOUNCE_FILTER_EDGE_EN is defined.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module debounce_filter #(
  parameter int CHANNELS    = 4,
  parameter int DEPTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int DIV         = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] sig_in,
  output logic [CHANNELS-1:0] sig_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                sample_tick
);

  localparam logic [15:0] c_presc_max = 16'(DIV - 1);

  logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
  logic [CHANNELS-1:0] w_sync;
  logic [15:0]         r_presc;
  logic                w_tick;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= sig_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (enable) begin
      r_presc <= (r_presc == c_presc_max) ? 16'd0 : r_presc + 16'd1;
    end
  end

  // Gated by reset so the tick is forced low while reset is held.
  assign w_tick      = reset & enable & (r_presc == c_presc_max);
  assign sample_tick = w_tick;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DEPTH-1:0] r_hist;
    logic [DEPTH-1:0] w_hist_next;
    logic             r_level;
    logic             w_level_next;

    assign w_hist_next = {r_hist[DEPTH-2:0], w_sync[i]};

    always_comb begin
      w_level_next = r_level;
      if (&w_hist_next)       w_level_next = 1'b1;
      else if (~|w_hist_next) w_level_next = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_hist  <= '0;
        r_level <= 1'b0;
      end else if (w_tick) begin
        r_hist  <= w_hist_next;
        r_level <= w_level_next;
      end
    end

    assign sig_out[i] = r_level;

`ifdef DEBOUNCE_FILTER_EDGE_EN
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_rise <= w_tick &  w_level_next & ~r_level;
        r_fall <= w_tick & ~w_level_next &  r_level;
      end
    end

    assign rise[i] = r_rise;
    assign fall[i] = r_fall;
`else
    assign rise[i] = 1'b0;
    assign fall[i] = 1'b0;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_debounce_filter.sv
//------------------------------------------------------------------------------
// Module   : tb_debounce_filter
// Brief    : Self-checking bench for debounce_filter (DIV=1 and DIV=4 instances).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_debounce_filter;

  localparam int DEPTH = 3;
  localparam int SYNC  = 2;
`ifdef DEBOUNCE_FILTER_EDGE_EN
  localparam logic EDGE_ON = 1'b1;
`else
  localparam logic EDGE_ON = 1'b0;
`endif

  logic       clock  = 1'b0;
  logic       reset  = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] sig_in = 4'h0;

  logic [3:0] out_a, rise_a, fall_a, out_b, rise_b, fall_b;
  logic       tick_a, tick_b;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  debounce_filter u_dut_a (
    .clock(clock), .reset(reset), .enable(enable), .sig_in(sig_in),
    .sig_out(out_a), .rise(rise_a), .fall(fall_a), .sample_tick(tick_a)
  );

  debounce_filter #(.DIV(4)) u_dut_b (
    .clock(clock), .reset(reset), .enable(enable), .sig_in(sig_in),
    .sig_out(out_b), .rise(rise_b), .fall(fall_b), .sample_tick(tick_b)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: input delayed by SYNC edges, last DEPTH samples per DUT,
  // tick whenever the count of enabled edges since reset hits DIV-1 mod DIV.
  logic [3:0] m_pipe [SYNC];
  logic [3:0] m_samp [2][DEPTH];
  logic [3:0] m_out  [2];
  logic [3:0] m_rise [2];
  logic [3:0] m_fall [2];
  int         m_cnt  [2];
  int         m_div  [2] = '{1, 4};

  task automatic m_clear();
    for (int s = 0; s < SYNC; s++) m_pipe[s] = 4'h0;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < DEPTH; k++) m_samp[d][k] = 4'h0;
      m_out[d] = 4'h0; m_rise[d] = 4'h0; m_fall[d] = 4'h0; m_cnt[d] = 0;
    end
  endtask

  task automatic m_step();
    logic [3:0] sval, ones, zeros, nxt;
    sval = m_pipe[0];
    for (int s = 0; s < SYNC - 1; s++) m_pipe[s] = m_pipe[s+1];
    m_pipe[SYNC-1] = sig_in;
    for (int d = 0; d < 2; d++) begin
      m_rise[d] = 4'h0;
      m_fall[d] = 4'h0;
      if (enable) begin
        if (m_cnt[d] % m_div[d] == m_div[d] - 1) begin
          for (int k = 0; k < DEPTH - 1; k++) m_samp[d][k] = m_samp[d][k+1];
          m_samp[d][DEPTH-1] = sval;
          ones = 4'hF; zeros = 4'hF;
          for (int k = 0; k < DEPTH; k++) begin
            ones  = ones  &  m_samp[d][k];
            zeros = zeros & ~m_samp[d][k];
          end
          nxt = (m_out[d] | ones) & ~zeros;
          if (EDGE_ON) begin
            m_rise[d] = nxt & ~m_out[d];
            m_fall[d] = ~nxt & m_out[d];
          end
          m_out[d] = nxt;
        end
        m_cnt[d]++;
      end
    end
  endtask

  function automatic logic exp_tick(input int d);
    return reset && enable && (m_cnt[d] % m_div[d] == m_div[d] - 1);
  endfunction

  initial begin
    m_clear();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) m_clear();
      else        m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      check("out_a",  out_a,  m_out[0]);
      check("rise_a", rise_a, m_rise[0]);
      check("fall_a", fall_a, m_fall[0]);
      check("out_b",  out_b,  m_out[1]);
      check("rise_b", rise_b, m_rise[1]);
      check("fall_b", fall_b, m_fall[1]);
      #3;
      check("tick_a", {3'b0, tick_a}, {3'b0, exp_tick(0)});
      check("tick_b", {3'b0, tick_b}, {3'b0, exp_tick(1)});
    end
  end

  initial begin
    logic [3:0] flip;
    int         rate;

    // Reset held with enable high: everything, including the tick, must be 0.
    repeat (3) @(posedge clock);
    #2;
    check("rst_out",  out_a, 4'h0);
    check("rst_tick", {3'b0, tick_a}, 4'h0);
    check("rst_rise", rise_a, 4'h0);

    @(negedge clock); #1 reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      #2;
      check("div4_tick", {3'b0, tick_b}, (k % 4 == 0) ? 4'h1 : 4'h0);
      check("div1_tick", {3'b0, tick_a}, 4'h1);
      @(negedge clock); #1;
    end

    // Clean step on channel 0: visible exactly 5 clocks later.
    sig_in = 4'b0001;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clock); #2;
      check("step_out0", {3'b0, out_a[0]}, (n == 5) ? 4'h1 : 4'h0);
      check("step_rise", rise_a, (n == 5) ? {3'b0, EDGE_ON} : 4'h0);
    end
    @(posedge clock); #2;
    check("step_rise_once", rise_a, 4'h0);

    // Two-clock glitch on channel 1 is filtered.
    @(negedge clock); #1 sig_in = 4'b0011;
    @(negedge clock); @(negedge clock); #1 sig_in = 4'b0001;
    repeat (10) @(posedge clock);
    #2;
    check("glitch_out", out_a, 4'b0001);

    // Enable dropped after two samples of channel 3; resumes on next tick.
    @(negedge clock); #1 sig_in = 4'b1001;
    repeat (4) @(posedge clock);
    @(negedge clock); #1 enable = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    check("hold_out3", {3'b0, out_a[3]}, 4'h0);
    @(negedge clock); #1 enable = 1'b1;
    @(posedge clock); #2;
    check("resume_out3", {3'b0, out_a[3]}, 4'h1);

    // All high, then asynchronous reset in mid-cycle.
    @(negedge clock); #1 sig_in = 4'hF;
    repeat (12) @(posedge clock);
    #2;
    check("all_high", out_a, 4'hF);
    reset = 1'b0;
    #1;
    check("async_rst_out",  out_a,  4'h0);
    check("async_rst_fall", fall_a, 4'h0);
    @(negedge clock); #1 reset = 1'b1;

    // Randomized traffic with alternating bounce rates and occasional resets.
    rate = 16;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock); #1;
      if (i % 200 == 0) rate = (rate == 16) ? 3 : 16;
      flip = 4'h0;
      for (int c = 0; c < 4; c++) flip[c] = ($urandom_range(0, rate - 1) == 0);
      sig_in = sig_in ^ flip;
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 499) == 0) begin
        @(posedge clock); #2 reset = 1'b0;
        @(negedge clock); #1 reset = 1'b1;
      end
    end

    repeat (4) @(posedge clock);
    #6;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
